char_fifo: RTL and testbench

- Parametrised, synchronous-reset successor to the 32-entry, 7-bit keyboard character FIFO.
- Generalised in data width, depth and almost-full threshold.
- Adds occupancy count, an almost-full flag, sticky overflow/underflow error flags, and write-through-when-full on a simultaneous read.
- Sits between the UART receiver (writer) and the CPU keyboard I/O port (reader); also reusable for the transmit path.

---
 rtl/kb_pkg.sv | 14 +
 rtl/char_fifo_if.sv | 30 +++
 rtl/char_fifo_mem.sv | 24 ++
 rtl/char_fifo.sv | 68 ++++++
 tb/tb_char_fifo.sv | 120 ++++++++++++
 5 files changed

// File: rtl/kb_pkg.sv
// kb_pkg: shared constants and helpers for the keyboard/UART character path
//   ASCII_W       default entry width (7-bit ASCII)
//   DEFAULT_DEPTH default FIFO depth
//   clog2()       ceiling log2, usable in constant expressions
package kb_pkg;
  localparam int ASCII_W = 7;
  localparam int DEFAULT_DEPTH = 32;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/char_fifo_if.sv
// char_fifo_if: bus between a FIFO user (master) and char_fifo (slave)
//   master drives wr_en/wr_data/rd_en/err_clear
//   slave drives rd_data, not_empty, full, almost_full, count, overflow, underflow
interface char_fifo_if
  import kb_pkg::*;
#(
  parameter int DATA_W = ASCII_W,
  parameter int DEPTH = DEFAULT_DEPTH
);
  localparam int ADDR_W = clog2(DEPTH);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic              err_clear;
  logic [DATA_W-1:0] rd_data;
  logic              not_empty;
  logic              full;
  logic              almost_full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;
  modport master (
    output wr_en, wr_data, rd_en, err_clear,
    input  rd_data, not_empty, full, almost_full, count, overflow, underflow
  );
  modport slave (
    input  wr_en, wr_data, rd_en, err_clear,
    output rd_data, not_empty, full, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/char_fifo_mem.sv
// char_fifo_mem: DEPTH x DATA_W storage, synchronous write, asynchronous read
//   clk        write clock
//   i_wr_en    write strobe
//   i_wr_addr  write index
//   i_wr_data  write data
//   i_rd_addr  read index
//   o_rd_data  combinational read data
module char_fifo_mem #(
  parameter int DATA_W = 7,
  parameter int DEPTH = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/char_fifo.sv
// char_fifo: parametrised first-word-fall-through character FIFO
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    char_fifo_if slave: write/read requests in; data, occupancy and
//          status (not_empty, full, almost_full, sticky overflow/underflow) out
module char_fifo
  import kb_pkg::*;
#(
  parameter int DATA_W = ASCII_W,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AF_LEVEL = DEPTH - 4
) (
  input logic       clk,
  input logic       reset,
  char_fifo_if.slave bus
);
  localparam int ADDR_W = clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);
  logic [ADDR_W:0] r_wr_ptr;
  logic [ADDR_W:0] r_rd_ptr;
  logic [ADDR_W:0] r_count;
  logic            r_overflow;
  logic            r_underflow;
  logic            w_rd_acc;
  logic            w_wr_acc;
  logic            w_ovf_set;
  logic            w_udf_set;
  assign bus.not_empty   = r_count != '0;
  assign bus.full        = r_count == FULL_CNT;
  assign bus.almost_full = r_count >= AF_CNT;
  assign bus.count       = r_count;
  assign bus.overflow    = r_overflow;
  assign bus.underflow   = r_underflow;
  assign w_rd_acc  = bus.rd_en & bus.not_empty;
  // a full FIFO still takes a write when a pop frees the slot in the same cycle
  assign w_wr_acc  = bus.wr_en & (~bus.full | w_rd_acc);
  assign w_ovf_set = bus.wr_en & ~w_wr_acc;
  assign w_udf_set = bus.rd_en & ~bus.not_empty;
  always_ff @(posedge clk)
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ONE;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + ONE;
      r_count     <= r_count + (ADDR_W + 1)'(w_wr_acc) - (ADDR_W + 1)'(w_rd_acc);
      // set wins over a same-cycle clear
      r_overflow  <= w_ovf_set | (r_overflow & ~bus.err_clear);
      r_underflow <= w_udf_set | (r_underflow & ~bus.err_clear);
    end
  char_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
    .i_wr_data (bus.wr_data),
    .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
    .o_rd_data (bus.rd_data)
  );
endmodule

// File: tb/tb_char_fifo.sv
// tb_char_fifo: directed self-checking bench for char_fifo
module tb_char_fifo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_pass = 0;
  int n_total = 0;
  char_fifo_if #(.DATA_W(7), .DEPTH(32)) bus ();
  char_fifo #(.DATA_W(7), .DEPTH(32), .AF_LEVEL(28)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask
  task automatic cyc(input logic w, input logic [6:0] wd, input logic r, input logic ec);
    bus.wr_en = w;
    bus.wr_data = wd;
    bus.rd_en = r;
    bus.err_clear = ec;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.err_clear = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  task automatic chk_flags(input string tag, input int cnt, input int ne, input int fl,
                           input int af, input int ov, input int uf);
    chk({tag, ".count"}, int'(bus.count), cnt);
    chk({tag, ".not_empty"}, int'(bus.not_empty), ne);
    chk({tag, ".full"}, int'(bus.full), fl);
    chk({tag, ".almost_full"}, int'(bus.almost_full), af);
    chk({tag, ".overflow"}, int'(bus.overflow), ov);
    chk({tag, ".underflow"}, int'(bus.underflow), uf);
  endtask
  initial begin
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.rd_en = 1'b0;
    bus.err_clear = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    chk_flags("reset", 0, 0, 0, 0, 0, 0);
    cyc(1, 7'h41, 0, 0);
    cyc(1, 7'h42, 0, 0);
    cyc(1, 7'h43, 0, 0);
    chk_flags("abc", 3, 1, 0, 0, 0, 0);
    chk("abc.head", int'(bus.rd_data), 'h41);
    cyc(0, 0, 1, 0);
    chk("pop1", int'(bus.rd_data), 'h42);
    cyc(0, 0, 1, 0);
    chk("pop2", int'(bus.rd_data), 'h43);
    cyc(0, 0, 1, 0);
    chk_flags("pop3", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) cyc(1, 7'(i), 0, 0);
    cyc(1, 7'h7f, 0, 0);
    chk_flags("ovf", 32, 1, 1, 1, 1, 0);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("drain%0d", i), int'(bus.rd_data), i);
      cyc(0, 0, 1, 0);
    end
    chk_flags("drained", 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    chk("ovf.clear", int'(bus.overflow), 0);
    for (int i = 0; i < 32; i++) cyc(1, 7'(i), 0, 0);
    cyc(1, 7'h55, 1, 0);
    chk_flags("wthru", 32, 1, 1, 1, 0, 0);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("wthru.drain%0d", i), int'(bus.rd_data), i < 31 ? i + 1 : 'h55);
      cyc(0, 0, 1, 0);
    end
    chk_flags("wthru.empty", 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    chk_flags("udf", 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    chk("udf.setwins", int'(bus.underflow), 1);
    cyc(0, 0, 0, 1);
    chk("udf.clear", int'(bus.underflow), 0);
    cyc(1, 7'h33, 1, 0);
    chk_flags("empty.wr_rd", 1, 1, 0, 0, 0, 1);
    chk("empty.wr_rd.data", int'(bus.rd_data), 'h33);
    cyc(0, 0, 1, 1);
    chk_flags("empty.wr_rd.pop", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 27; i++) cyc(1, 7'(i + 'h20), 0, 0);
    chk_flags("af27", 27, 1, 0, 0, 0, 0);
    cyc(1, 7'h3b, 0, 0);
    chk_flags("af28", 28, 1, 0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    chk_flags("af.pop", 27, 1, 0, 0, 0, 0);
    chk("af.pop.head", int'(bus.rd_data), 'h21);
    do_reset();
    cyc(1, 7'h00, 0, 0);
    for (int i = 1; i < 100; i++) begin
      cyc(1, 7'((i * 37 + 5) & 'h7f), 1, 0);
      chk($sformatf("stream%0d", i), int'(bus.rd_data), ((i * 37 + 5) & 'h7f));
      chk($sformatf("stream%0d.count", i), int'(bus.count), 1);
    end
    cyc(0, 0, 1, 0);
    chk_flags("stream.end", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 7'(i + 1), 0, 0);
    chk("pre_reset.count", int'(bus.count), 10);
    do_reset();
    chk_flags("mid_reset", 0, 0, 0, 0, 0, 0);
    cyc(1, 7'h61, 0, 0);
    chk_flags("post_reset", 1, 1, 0, 0, 0, 0);
    chk("post_reset.data", int'(bus.rd_data), 'h61);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
